// File: rtl/lifi_axis_pkg.sv
// Shared definitions for the LiFi OFDM transmit AXI4-Stream rate-change stages.
package lifi_axis_pkg;

    localparam int HOLD_ZERO   = 0;
    localparam int HOLD_REPEAT = 1;

    function automatic logic [31:0] sext16to32(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

endpackage

// File: rtl/axis_upsampler.sv
// Integer-factor AXI4-Stream upsampler: each sample becomes UP_FACTOR beats (zero-stuffed or held).
// Latency: phase-0 beat valid the cycle after the input handshake; one beat per cycle sustained.
// Backpressure: m_axis_tready low freezes phase/sample/output; s_axis_tready only opens on the last phase.
module axis_upsampler
    import lifi_axis_pkg::*;
#(
    parameter int UP_FACTOR = 4,
    parameter int HOLD_MODE = HOLD_ZERO
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast
);

    localparam int              PH_W    = $clog2(UP_FACTOR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(UP_FACTOR - 1);
    localparam bit              REPEAT  = (HOLD_MODE == HOLD_REPEAT);

    logic            full;
    logic [15:0]     smp;
    logic            lst;
    logic [PH_W-1:0] ph;

    logic last_ph;
    logic in_hs;
    logic out_hs;
    logic unused_hi;

    assign last_ph   = (ph == PH_LAST);
    assign out_hs    = full & m_axis_tready;
    assign in_hs     = s_axis_tvalid & s_axis_tready;
    assign unused_hi = ^s_axis_tdata[31:16];

    // Held low during reset so nothing is accepted into a clearing pipeline.
    assign s_axis_tready = aresetn & (~full | (last_ph & m_axis_tready));

    assign m_axis_tvalid = full;
    assign m_axis_tdata  = (ph == '0 || REPEAT) ? sext16to32(smp) : 32'h0;
    assign m_axis_tlast  = lst & last_ph;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full <= 1'b0;
            smp  <= 16'h0;
            lst  <= 1'b0;
            ph   <= '0;
        end else if (in_hs) begin
            // Covers both the empty load and the back-to-back reload on the last phase.
            full <= 1'b1;
            smp  <= s_axis_tdata[15:0];
            lst  <= s_axis_tlast;
            ph   <= '0;
        end else if (out_hs) begin
            if (last_ph) begin
                full <= 1'b0;
                ph   <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_upsampler.sv
// Bench for axis_upsampler: three instances (L=4 zero-stuff, L=4 hold, L=2 zero-stuff).
module tb_axis_upsampler;

    logic        aclk;
    logic        aresetn;
    logic        s_rdy [3];
    logic [31:0] s_dat [3];
    logic        s_vld [3];
    logic        s_lst [3];
    logic        m_rdy [3];
    logic [31:0] m_dat [3];
    logic        m_vld [3];
    logic        m_lst [3];

    int total;
    int bad;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    axis_upsampler #(.UP_FACTOR(4), .HOLD_MODE(0)) u_z4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(s_rdy[0]), .s_axis_tdata(s_dat[0]), .s_axis_tvalid(s_vld[0]), .s_axis_tlast(s_lst[0]),
        .m_axis_tready(m_rdy[0]), .m_axis_tdata(m_dat[0]), .m_axis_tvalid(m_vld[0]), .m_axis_tlast(m_lst[0])
    );

    axis_upsampler #(.UP_FACTOR(4), .HOLD_MODE(1)) u_h4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(s_rdy[1]), .s_axis_tdata(s_dat[1]), .s_axis_tvalid(s_vld[1]), .s_axis_tlast(s_lst[1]),
        .m_axis_tready(m_rdy[1]), .m_axis_tdata(m_dat[1]), .m_axis_tvalid(m_vld[1]), .m_axis_tlast(m_lst[1])
    );

    axis_upsampler #(.UP_FACTOR(2), .HOLD_MODE(0)) u_z2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(s_rdy[2]), .s_axis_tdata(s_dat[2]), .s_axis_tvalid(s_vld[2]), .s_axis_tlast(s_lst[2]),
        .m_axis_tready(m_rdy[2]), .m_axis_tdata(m_dat[2]), .m_axis_tvalid(m_vld[2]), .m_axis_tlast(m_lst[2])
    );

    typedef struct {
        logic        sv;
        logic [15:0] sd;
        logic        sl;
        logic        mr;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        er;
        logic        cd;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    vec_t  tbl [15];
    beat_t exp_q [$];

    function automatic vec_t mk(input logic sv, input logic [15:0] sd, input logic sl, input logic mr,
                                input logic ev, input logic [31:0] ed, input logic el, input logic er,
                                input logic cd);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] d, input logic l, input logic r);
        s_vld[i] = v;
        s_dat[i] = d;
        s_lst[i] = l;
        m_rdy[i] = r;
    endtask

    initial begin
        logic [31:0] bp_exp [4];
        logic        bp_mr  [10];
        logic [31:0] prev_d;
        logic        prev_stall;
        int          beats;
        int          n_in, n_out, cyc, tl_in, tl_out;
        logic        acc;
        beat_t       b;

        total = 0;
        bad   = 0;
        aresetn = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 1'b0, 1'b0);

        // cycle-by-cycle table for L=4 zero-stuff: back-to-back samples, then a tlast sample
        tbl[0]  = mk(1, 16'h1234, 0, 1,  0, 32'h00000000, 0, 1, 1);
        tbl[1]  = mk(1, 16'h8001, 0, 1,  1, 32'h00001234, 0, 0, 1);
        tbl[2]  = mk(1, 16'h8001, 0, 1,  1, 32'h00000000, 0, 0, 1);
        tbl[3]  = mk(1, 16'h8001, 0, 1,  1, 32'h00000000, 0, 0, 1);
        tbl[4]  = mk(1, 16'h8001, 0, 1,  1, 32'h00000000, 0, 1, 1);
        tbl[5]  = mk(0, 16'h0000, 0, 1,  1, 32'hFFFF8001, 0, 0, 1);
        tbl[6]  = mk(0, 16'h0000, 0, 1,  1, 32'h00000000, 0, 0, 1);
        tbl[7]  = mk(0, 16'h0000, 0, 1,  1, 32'h00000000, 0, 0, 1);
        tbl[8]  = mk(0, 16'h0000, 0, 1,  1, 32'h00000000, 0, 1, 1);
        tbl[9]  = mk(1, 16'h0005, 1, 1,  0, 32'h00000000, 0, 1, 0);
        tbl[10] = mk(0, 16'h0000, 0, 1,  1, 32'h00000005, 0, 0, 1);
        tbl[11] = mk(0, 16'h0000, 0, 1,  1, 32'h00000000, 0, 0, 1);
        tbl[12] = mk(0, 16'h0000, 0, 1,  1, 32'h00000000, 0, 0, 1);
        tbl[13] = mk(0, 16'h0000, 0, 1,  1, 32'h00000000, 1, 1, 1);
        tbl[14] = mk(0, 16'h0000, 0, 1,  0, 32'h00000000, 0, 1, 0);

        // reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_s_rdy%0d", i), {31'b0, s_rdy[i]}, 32'd0);
            chk($sformatf("rst_m_vld%0d", i), {31'b0, m_vld[i]}, 32'd0);
            chk($sformatf("rst_m_dat%0d", i), m_dat[i], 32'd0);
            chk($sformatf("rst_m_lst%0d", i), {31'b0, m_lst[i]}, 32'd0);
        end
        aresetn = 1'b1;

        for (int r = 0; r < 15; r++) begin
            @(posedge aclk); #1;
            drive(0, tbl[r].sv, {16'hABCD, tbl[r].sd}, tbl[r].sl, tbl[r].mr);
            @(negedge aclk);
            chk($sformatf("tbl%0d_m_vld", r), {31'b0, m_vld[0]}, {31'b0, tbl[r].ev});
            chk($sformatf("tbl%0d_m_lst", r), {31'b0, m_lst[0]}, {31'b0, tbl[r].el});
            chk($sformatf("tbl%0d_s_rdy", r), {31'b0, s_rdy[0]}, {31'b0, tbl[r].er});
            if (tbl[r].cd) chk($sformatf("tbl%0d_m_dat", r), m_dat[0], tbl[r].ed);
        end

        // hold mode: one sample repeated on all four phases
        @(posedge aclk); #1;
        drive(1, 1'b1, 32'h0000FFFE, 1'b0, 1'b1);
        @(negedge aclk);
        chk("hold_s_rdy", {31'b0, s_rdy[1]}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge aclk); #1;
            drive(1, 1'b0, 32'h0, 1'b0, 1'b1);
            @(negedge aclk);
            chk($sformatf("hold_vld%0d", k), {31'b0, m_vld[1]}, 32'd1);
            chk($sformatf("hold_dat%0d", k), m_dat[1], 32'hFFFFFFFE);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("hold_done_vld", {31'b0, m_vld[1]}, 32'd0);

        // backpressure: stalls must freeze output without losing or repeating a beat
        bp_exp[0] = 32'h00000777; bp_exp[1] = 32'h0; bp_exp[2] = 32'h0; bp_exp[3] = 32'h0;
        bp_mr[0] = 1; bp_mr[1] = 0; bp_mr[2] = 0; bp_mr[3] = 1; bp_mr[4] = 1;
        bp_mr[5] = 0; bp_mr[6] = 1; bp_mr[7] = 0; bp_mr[8] = 1; bp_mr[9] = 1;
        @(posedge aclk); #1;
        drive(0, 1'b1, 32'h00000777, 1'b1, 1'b0);
        @(negedge aclk);
        beats = 0;
        prev_stall = 1'b0;
        prev_d = 32'h0;
        for (int c = 0; c < 10 && beats < 4; c++) begin
            @(posedge aclk); #1;
            drive(0, 1'b0, 32'h0, 1'b0, bp_mr[c]);
            @(negedge aclk);
            chk($sformatf("bp%0d_vld", c), {31'b0, m_vld[0]}, 32'd1);
            if (prev_stall) chk($sformatf("bp%0d_stable", c), m_dat[0], prev_d);
            if (m_vld[0] && m_rdy[0]) begin
                chk($sformatf("bp_beat%0d_dat", beats), m_dat[0], bp_exp[beats]);
                chk($sformatf("bp_beat%0d_lst", beats), {31'b0, m_lst[0]}, {31'b0, beats == 3});
                beats++;
            end
            prev_stall = m_vld[0] & ~m_rdy[0];
            prev_d = m_dat[0];
        end
        chk("bp_beats", beats, 32'd4);
        @(posedge aclk); #1;
        drive(0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge aclk);
        chk("bp_done_vld", {31'b0, m_vld[0]}, 32'd0);

        // asynchronous reset in the middle of phase 2
        @(posedge aclk); #1;
        drive(0, 1'b1, 32'h00000321, 1'b0, 1'b1);
        @(posedge aclk); #1;
        drive(0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge aclk);
        #3;
        chk("arst_pre_vld", {31'b0, m_vld[0]}, 32'd1);
        aresetn = 1'b0;
        #1;
        chk("arst_vld", {31'b0, m_vld[0]}, 32'd0);
        chk("arst_s_rdy", {31'b0, s_rdy[0]}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        drive(0, 1'b1, 32'h00000456, 1'b0, 1'b1);
        @(negedge aclk);
        chk("arst_after_vld", {31'b0, m_vld[0]}, 32'd0);
        chk("arst_after_s_rdy", {31'b0, s_rdy[0]}, 32'd1);
        @(posedge aclk); #1;
        drive(0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge aclk);
        chk("arst_ph0_dat", m_dat[0], 32'h00000456);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("arst_ph1_dat", m_dat[0], 32'h0);

        // L=2 random valid/ready against a zero-stuffing queue model
        n_in = 0; n_out = 0; cyc = 0; tl_in = 0; tl_out = 0;
        acc = 1'b0;
        while (n_out < 2000 && cyc < 30000) begin
            @(posedge aclk); #1;
            if (acc || !s_vld[2]) begin
                if (n_in < 1000 && $urandom_range(0, 1) == 1) begin
                    s_vld[2] = 1'b1;
                    s_dat[2] = $urandom;
                    s_lst[2] = ($urandom_range(0, 3) == 0);
                end else begin
                    s_vld[2] = 1'b0;
                end
            end
            m_rdy[2] = ($urandom_range(0, 1) == 1);
            @(negedge aclk);
            cyc++;
            if (m_vld[2] && m_rdy[2]) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_beat", {31'b0, m_vld[2]}, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk($sformatf("rnd%0d_dat", n_out), m_dat[2], b.d);
                    chk($sformatf("rnd%0d_lst", n_out), {31'b0, m_lst[2]}, {31'b0, b.l});
                end
                if (m_lst[2]) tl_out++;
                n_out++;
            end
            acc = s_vld[2] & s_rdy[2];
            if (acc) begin
                b.d = 32'($signed(s_dat[2][15:0]));
                b.l = 1'b0;
                exp_q.push_back(b);
                b.d = 32'h0;
                b.l = s_lst[2];
                exp_q.push_back(b);
                if (s_lst[2]) tl_in++;
                n_in++;
            end
        end
        chk("rnd_beats", n_out, 32'd2000);
        chk("rnd_samples", n_in, 32'd1000);
        chk("rnd_tlast_count", tl_out, tl_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
